cirno9_mem_arb: RTL and testbench

Parametrised N-channel arbiter in front of the single synchronous SRAM port of the cirno9 core. It replaces the fixed fetch/load-store/slave muxing with CH_NUM symmetric request channels, each using the core's val/rdy handshake. It holds a grant stable while the SRAM stalls, and routes one-cycle-latency read data back with a per-channel response strobe. It sits between the fetch, execute load/store and bus-slave requesters and the top-level `o_sram_*` pins.

---
 rtl/cirno9_mem_arb.sv | 132 +++++++++++++
 tb/tb_cirno9_mem_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_mem_arb.sv
// CH_NUM-channel val/rdy arbiter onto one synchronous SRAM port; grant locks while the SRAM stalls, reads respond 1 cycle later.
// Define CIRNO9_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with channel 0 highest.
module cirno9_mem_arb #(
   parameter int CH_NUM = 3,
   parameter int AW     = 32,
   parameter int DW     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CH_NUM-1:0]        i_req_val,
   output logic [CH_NUM-1:0]        o_req_rdy,
   input  logic [CH_NUM*AW-1:0]     i_req_adr,
   input  logic [CH_NUM*DW-1:0]     i_req_wdat,
   input  logic [CH_NUM*DW/8-1:0]   i_req_wen,
   input  logic [CH_NUM-1:0]        i_req_ren,
   output logic [CH_NUM-1:0]        o_rsp_val,
   output logic [DW-1:0]            o_rdat,
   input  logic                     i_hs_ram_rdy,
   input  logic [DW-1:0]            i_sram_rdat,
   output logic                     o_sram_ren,
   output logic [DW/8-1:0]          o_sram_wen,
   output logic [AW-1:0]            o_adr,
   output logic [DW-1:0]            o_wdat
);
   localparam int BW = DW / 8;
   localparam int IW = $clog2(CH_NUM);

   logic          lock_q;
   logic [IW-1:0] lock_idx_q;
   logic          rsp_pend_q;
   logic [IW-1:0] rsp_idx_q;
   logic          pick_vld;
   logic [IW-1:0] pick_idx;
   logic          win;
   logic [IW-1:0] g;
   logic          sel_ren;
   logic          accept;

`ifdef CIRNO9_ARB_RR_EN
   logic [IW-1:0] ptr_q;
   int            rr_idx;

   // Walk downward so the valid channel closest to the pointer is assigned last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      rr_idx   = 0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         rr_idx = (int'(ptr_q) + k) % CH_NUM;
         if (i_req_val[IW'(rr_idx)]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(rr_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= IW'((int'(g) + 1) % CH_NUM);
      end
   end
`else
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int c = CH_NUM - 1; c >= 0; c--) begin
         if (i_req_val[IW'(c)]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(c);
         end
      end
   end
`endif

   // A locked channel that drops val yields no winner at all, so no access leaks out.
   always_comb begin
      win = pick_vld;
      g   = pick_idx;
      if (lock_q) begin
         win = i_req_val[lock_idx_q];
         g   = lock_idx_q;
      end
   end

   always_comb begin
      o_adr      = '0;
      o_wdat     = '0;
      o_sram_wen = '0;
      sel_ren    = 1'b0;
      o_req_rdy  = '0;
      if (win) begin
         o_adr        = i_req_adr[int'(g)*AW +: AW];
         o_wdat       = i_req_wdat[int'(g)*DW +: DW];
         o_sram_wen   = i_req_wen[int'(g)*BW +: BW];
         sel_ren      = i_req_ren[g];
         o_req_rdy[g] = i_hs_ram_rdy;
      end
   end

   assign o_sram_ren = sel_ren & ~|o_sram_wen;
   assign accept     = win & i_hs_ram_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rsp_pend_q <= 1'b0;
         rsp_idx_q  <= '0;
      end else begin
         lock_q <= win & ~i_hs_ram_rdy;
         if (win & ~i_hs_ram_rdy) begin
            lock_idx_q <= g;
         end
         rsp_pend_q <= accept & o_sram_ren;
         if (accept) begin
            rsp_idx_q <= g;
         end
      end
   end

   always_comb begin
      o_rsp_val = '0;
      if (rsp_pend_q) begin
         o_rsp_val[rsp_idx_q] = 1'b1;
      end
   end

   assign o_rdat = rsp_pend_q ? i_sram_rdat : '0;

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Scoreboard bench for cirno9_mem_arb: directed scenarios plus randomized traffic against a behavioural arbitration model.
module tb_cirno9_mem_arb;
   localparam int CH = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [CH-1:0]    val;
   logic [CH-1:0]    req_rdy;
   logic [CH*AW-1:0] req_adr;
   logic [CH*DW-1:0] req_wdat;
   logic [CH*BW-1:0] req_wen;
   logic [CH-1:0]    req_ren;
   logic [CH-1:0]    rsp_val;
   logic [DW-1:0]    rdat;
   logic             hs_rdy;
   logic [DW-1:0]    sram_rdat;
   logic             sram_ren;
   logic [BW-1:0]    sram_wen;
   logic [AW-1:0]    adr;
   logic [DW-1:0]    wdat;

   logic [AW-1:0] r_adr  [CH];
   logic [DW-1:0] r_wdat [CH];
   logic [BW-1:0] r_wen  [CH];
   logic          r_ren  [CH];

   for (genvar c = 0; c < CH; c++) begin : g_pack
      assign req_adr[c*AW +: AW]  = r_adr[c];
      assign req_wdat[c*DW +: DW] = r_wdat[c];
      assign req_wen[c*BW +: BW]  = r_wen[c];
      assign req_ren[c]           = r_ren[c];
   end

   cirno9_mem_arb #(.CH_NUM(CH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_val(val), .o_req_rdy(req_rdy),
      .i_req_adr(req_adr), .i_req_wdat(req_wdat), .i_req_wen(req_wen), .i_req_ren(req_ren),
      .o_rsp_val(rsp_val), .o_rdat(rdat),
      .i_hs_ram_rdy(hs_rdy), .i_sram_rdat(sram_rdat),
      .o_sram_ren(sram_ren), .o_sram_wen(sram_wen), .o_adr(adr), .o_wdat(wdat)
   );

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   // Synchronous SRAM: data for an accepted read appears the cycle after.
   always @(posedge clk) begin
      if (sram_ren && hs_rdy) sram_rdat <= mem_f(adr);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int            ch;
      logic [AW-1:0] a;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t e;
   int   acc_log[$];
   int   lock_ch = -1;
   int   ptr = 0;
   bit   refill = 0;
   bit   mon_en = 0;

   function automatic int model_winner();
      if (lock_ch >= 0) return val[lock_ch] ? lock_ch : -1;
`ifdef CIRNO9_ARB_RR_EN
      for (int k = 0; k < CH; k++) if (val[(ptr + k) % CH]) return (ptr + k) % CH;
`else
      for (int c = 0; c < CH; c++) if (val[c]) return c;
`endif
      return -1;
   endfunction

   task automatic req(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] we, input logic re);
      r_adr[c] = a; r_wdat[c] = d; r_wen[c] = we; r_ren[c] = re; val[c] = 1'b1;
   endtask

   // One clock: check pins at negedge, advance the model at posedge, retire the accepted request.
   task automatic cycle();
      int w;
      bit acc;
      bit rd;
      logic [AW-1:0] ea; logic [DW-1:0] ed; logic [BW-1:0] ew; logic er; logic [CH-1:0] erdy;
      @(negedge clk);
      w = model_winner();
      ea = '0; ed = '0; ew = '0; er = 1'b0; erdy = '0;
      if (w >= 0) begin
         ea = r_adr[w]; ed = r_wdat[w]; ew = r_wen[w];
         er = r_ren[w] && (r_wen[w] == '0);
         erdy[w] = hs_rdy;
      end
      chk("sram_adr", adr, ea);
      chk("sram_wdat", wdat, ed);
      chk("sram_wen", sram_wen, ew);
      chk("sram_ren", sram_ren, er);
      chk("req_rdy", req_rdy, erdy);
      rd  = er;
      acc = (w >= 0) && hs_rdy;
      @(posedge clk);
      if (acc) begin
         acc_log.push_back(w);
         if (rd) exp_q.push_back('{ch: w, a: ea});
         ptr = (w + 1) % CH;
         lock_ch = -1;
      end else begin
         lock_ch = w;
      end
      #1;
      if (acc) begin
         val[w] = 1'b0;
         if (refill) req(w, $urandom & 32'hFFFF_FFFC, $urandom, '0, 1'b1);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_val", rsp_val, 64'(1) << e.ch);
            chk("rsp_rdat", rdat, mem_f(e.a));
         end else begin
            chk("rsp_idle", rsp_val, '0);
         end
      end
   end

   initial begin
      rst_n = 1'b1; val = '0; hs_rdy = 1'b1;
      for (int c = 0; c < CH; c++) begin
         r_adr[c] = '0; r_wdat[c] = '0; r_wen[c] = '0; r_ren[c] = 1'b0;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("reset_rsp_val", rsp_val, '0);
      chk("reset_rdat", rdat, '0);
      chk("reset_adr", adr, '0);
      chk("reset_sram_ren", sram_ren, '0);
      chk("reset_req_rdy", req_rdy, '0);
      mon_en = 1;
      @(posedge clk); #1 rst_n = 1'b1;

      // Three simultaneous reads drain in index order.
      req(0, 32'h10, '0, '0, 1'b1); req(1, 32'h20, '0, '0, 1'b1); req(2, 32'h30, '0, '0, 1'b1);
      acc_log.delete();
      repeat (3) cycle();
      chk("fp_order_n", acc_log.size(), 3);
      for (int i = 0; i < 3 && i < acc_log.size(); i++) chk("fp_order", acc_log[i], i);

      // Continuously valid channels for six accepts.
      refill = 1;
      req(0, 32'h40, '0, '0, 1'b1); req(1, 32'h44, '0, '0, 1'b1); req(2, 32'h48, '0, '0, 1'b1);
      acc_log.delete();
      repeat (6) cycle();
      refill = 0; val = '0;
      chk("cont_order_n", acc_log.size(), 6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
`ifdef CIRNO9_ARB_RR_EN
         chk("rr_order", acc_log[i], i % 3);
`else
         chk("fp_starve_order", acc_log[i], 0);
`endif
      end

      // Stalled write on ch1 keeps the grant while ch0 arrives.
      acc_log.delete();
      req(1, 32'h80, 32'hDEAD_BEEF, 4'hF, 1'b0);
      hs_rdy = 1'b0; cycle();
      req(0, 32'h90, '0, '0, 1'b1);
      cycle(); cycle();
      hs_rdy = 1'b1; cycle(); cycle();
      chk("stall_order_n", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         chk("stall_first", acc_log[0], 1);
         chk("stall_second", acc_log[1], 0);
      end

      // Back-to-back reads on ch2.
      acc_log.delete();
      req(2, 32'h100, '0, '0, 1'b1); cycle();
      req(2, 32'h104, '0, '0, 1'b1); cycle();
      cycle();
      chk("b2b_n", acc_log.size(), 2);

      // Reset between accept and response.
      req(0, 32'h200, '0, '0, 1'b1); cycle();
      rst_n = 1'b0; exp_q.delete(); lock_ch = -1; ptr = 0;
      #2 rst_n = 1'b1;
      acc_log.delete();
      req(0, 32'h210, '0, '0, 1'b1); req(1, 32'h214, '0, '0, 1'b1); req(2, 32'h218, '0, '0, 1'b1);
      cycle();
      val = '0;
      chk("post_reset_grant", acc_log.size() > 0 ? acc_log[0] : -1, 0);

      // Write with ren also set must not read.
      req(0, 32'h300, 32'h1234_5678, 4'h3, 1'b1); cycle();
      cycle();

      // Random traffic, including stalls and the occasional illegal val drop.
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (!val[c] && $urandom_range(0, 2) == 0)
               req(c, $urandom, $urandom, ($urandom_range(0, 2) == 0) ? BW'($urandom) : '0, 1'($urandom));
         end
         if ($urandom_range(0, 39) == 0) val[$urandom_range(0, CH - 1)] = 1'b0;
         hs_rdy = ($urandom_range(0, 3) != 0);
         cycle();
      end
      val = '0; hs_rdy = 1'b1;
      cycle(); cycle();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
